// File: rtl/vproc_pending_wr_tracker_if.sv
// Bundle of the dispatch / writeback / retire / hazard signals exchanged
// between the vector core pipeline and the pending-write tracker.
// The master side is the pipeline; the slave side is the tracker itself.
interface vproc_pending_wr_tracker_if #(
  parameter int unsigned INSTR_ID_W = 3
);

  // Pipeline kill
  logic                  flush_i;

  // Dispatch handshake
  logic                  dispatch_valid_i;
  logic                  dispatch_ready_o;
  logic [INSTR_ID_W-1:0] dispatch_id_o;
  logic [31:0]           dispatch_pend_i;

  // Partial writeback notification
  logic                  clear_valid_i;
  logic [INSTR_ID_W-1:0] clear_id_i;
  logic [31:0]           clear_mask_i;

  // Retirement
  logic                  retire_valid_i;
  logic [INSTR_ID_W-1:0] retire_id_i;

  // Hazard query from decode and status
  logic [31:0]           rd_mask_i;
  logic [31:0]           pending_wr_o;
  logic                  hazard_o;
  logic                  idle_o;
  logic                  err_o;

  modport master (
    output flush_i,
    output dispatch_valid_i,
    input  dispatch_ready_o,
    input  dispatch_id_o,
    output dispatch_pend_i,
    output clear_valid_i,
    output clear_id_i,
    output clear_mask_i,
    output retire_valid_i,
    output retire_id_i,
    output rd_mask_i,
    input  pending_wr_o,
    input  hazard_o,
    input  idle_o,
    input  err_o
  );

  modport slave (
    input  flush_i,
    input  dispatch_valid_i,
    output dispatch_ready_o,
    output dispatch_id_o,
    input  dispatch_pend_i,
    input  clear_valid_i,
    input  clear_id_i,
    input  clear_mask_i,
    input  retire_valid_i,
    input  retire_id_i,
    input  rd_mask_i,
    output pending_wr_o,
    output hazard_o,
    output idle_o,
    output err_o
  );

endinterface

// File: rtl/vproc_pending_wr_tracker.sv
// Pending vector-register-write tracker.
// One slot per in-flight instruction holds a valid flag and a 32-bit mask of
// vregs it has yet to write. Slots are allocated lowest-free-first at dispatch,
// shrunk by writeback clears and released at retirement. The OR of all live
// masks feeds the RAW/WAW hazard check in decode.
module vproc_pending_wr_tracker #(
  parameter int unsigned INSTR_ID_W     = 3,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             async_rst_i,
  vproc_pending_wr_tracker_if.slave        bus_if
);

  localparam int unsigned N = 1 << INSTR_ID_W;

  // Flattened view of the per-slot registers
  logic [N-1:0]          valid_vec;
  logic [31:0]           mask_arr [N];

  // Allocation
  logic [INSTR_ID_W-1:0] free_id;
  logic                  ready;
  logic                  dispatch_fire;

  // Error pulse and aggregated mask
  logic                  err_q;
  logic                  err_d;
  logic                  clear_to_free;
  logic                  retire_to_free;
  logic [31:0]           pending;

  // Lowest-index free slot, derived from registered state only so that a slot
  // released this cycle is never handed out before the edge.
  always_comb begin
    free_id = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_id = INSTR_ID_W'(i);
      end
    end
  end

  assign ready = ~&valid_vec;

  // A flush drops any dispatch presented in the same cycle.
  assign dispatch_fire = bus_if.dispatch_valid_i & ready & ~bus_if.flush_i;

  // Per-slot state: valid flag plus pending-write mask.
  genvar gi;
  generate
    for (gi = 0; gi < int'(N); gi++) begin : g_slot
      localparam logic [INSTR_ID_W-1:0] SLOT_ID = INSTR_ID_W'(gi);

      logic        valid_q;
      logic        valid_d;
      logic [31:0] mask_q;
      logic [31:0] mask_d;
      logic        disp_hit;
      logic        clear_hit;
      logic        retire_hit;

      // Clear and retire only act on a live slot; dispatch only ever targets a
      // free one, so it cannot overlap with either of them.
      assign disp_hit   = dispatch_fire && (free_id == SLOT_ID);
      assign clear_hit  = bus_if.clear_valid_i && (bus_if.clear_id_i == SLOT_ID) && valid_q;
      assign retire_hit = bus_if.retire_valid_i && (bus_if.retire_id_i == SLOT_ID) && valid_q;

      // Next-state: flush beats everything, retire beats a same-slot clear,
      // and a freed slot always carries an all-zero mask.
      always_comb begin
        valid_d = valid_q;
        mask_d  = mask_q;
        if (bus_if.flush_i) begin
          valid_d = 1'b0;
          mask_d  = '0;
        end else if (retire_hit) begin
          valid_d = 1'b0;
          mask_d  = '0;
        end else if (disp_hit) begin
          valid_d = 1'b1;
          mask_d  = bus_if.dispatch_pend_i;
        end else if (clear_hit) begin
          mask_d  = mask_q & ~bus_if.clear_mask_i;
        end
      end

      // Slot register with asynchronous reset.
      always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
          valid_q <= 1'b0;
          mask_q  <= '0;
        end else begin
          valid_q <= valid_d;
          mask_q  <= mask_d;
        end
      end

      assign valid_vec[gi] = valid_q;
      assign mask_arr[gi]  = mask_q;
    end
  endgenerate

  // Misdirected retire or clear: flagged, but never allowed to touch state.
  assign clear_to_free  = bus_if.clear_valid_i  & ~valid_vec[bus_if.clear_id_i];
  assign retire_to_free = bus_if.retire_valid_i & ~valid_vec[bus_if.retire_id_i];
  assign err_d          = ~bus_if.flush_i & (clear_to_free | retire_to_free);

  // Registered one-cycle error pulse.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // OR of every slot mask; free slots are zero so no valid gating is needed.
  always_comb begin
    pending = '0;
    for (int i = 0; i < int'(N); i++) begin
      pending = pending | mask_arr[i];
    end
  end

  assign bus_if.dispatch_ready_o = ready;
  assign bus_if.dispatch_id_o    = ready ? free_id :
                                   (DONT_CARE_ZERO ? '0 : 'x);
  assign bus_if.pending_wr_o     = pending;
  // Hazard looks only at registered state: no bypass of this cycle's dispatch.
  assign bus_if.hazard_o         = |(bus_if.rd_mask_i & pending);
  assign bus_if.idle_o           = ~|valid_vec;
  assign bus_if.err_o            = err_q;

endmodule

// File: tb/tb_vproc_pending_wr_tracker.sv
// Self-checking bench for the pending-write tracker: directed scenarios with
// literal expectations, then randomized traffic compared cycle by cycle with a
// slot-table model of the tracker's rules.
module tb_vproc_pending_wr_tracker;

  localparam int NS = 8;

  logic clk;
  logic rst;

  vproc_pending_wr_tracker_if #(.INSTR_ID_W(3)) bus_if ();

  vproc_pending_wr_tracker #(
    .INSTR_ID_W     (3),
    .DONT_CARE_ZERO (1'b0)
  ) dut (
    .clk_i       (clk),
    .async_rst_i (rst),
    .bus_if      (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: a table of instructions in flight
  bit          m_valid [NS];
  logic [31:0] m_mask  [NS];
  bit          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_first_free();
    for (int i = 0; i < NS; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) if (m_valid[i]) r = r | m_mask[i];
    return r;
  endfunction

  function automatic bit m_idle();
    for (int i = 0; i < NS; i++) if (m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_mask[i]  = '0;
    end
    m_err = 1'b0;
  endtask

  // Apply one clock edge of the tracker's rules to the model.
  task automatic model_edge();
    int  ff;
    int  rid;
    int  cid;
    bit  e;
    if (bus_if.flush_i) begin
      model_reset();
      return;
    end
    ff  = m_first_free();
    rid = int'(bus_if.retire_id_i);
    cid = int'(bus_if.clear_id_i);
    e   = (bus_if.retire_valid_i && !m_valid[rid]) || (bus_if.clear_valid_i && !m_valid[cid]);
    if (bus_if.clear_valid_i && m_valid[cid]) m_mask[cid] = m_mask[cid] & ~bus_if.clear_mask_i;
    if (bus_if.retire_valid_i && m_valid[rid]) begin
      m_valid[rid] = 1'b0;
      m_mask[rid]  = '0;
    end
    if (bus_if.dispatch_valid_i && ff >= 0) begin
      m_valid[ff] = 1'b1;
      m_mask[ff]  = bus_if.dispatch_pend_i;
      $display("txn dispatch id=%0d pend=%08h", ff, bus_if.dispatch_pend_i);
    end
    m_err = e;
  endtask

  // Every rising edge goes through here so the model never misses one.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    bus_if.flush_i          = 1'b0;
    bus_if.dispatch_valid_i = 1'b0;
    bus_if.dispatch_pend_i  = '0;
    bus_if.clear_valid_i    = 1'b0;
    bus_if.clear_id_i       = '0;
    bus_if.clear_mask_i     = '0;
    bus_if.retire_valid_i   = 1'b0;
    bus_if.retire_id_i      = '0;
  endtask

  task automatic dispatch(input logic [31:0] pend);
    set_idle();
    bus_if.dispatch_valid_i = 1'b1;
    bus_if.dispatch_pend_i  = pend;
    tick();
    set_idle();
  endtask

  // Compare process: model vs DUT on every falling edge outside reset.
  always @(negedge clk) begin
    int ff;
    if (cmp_en && !rst) begin
      ff = m_first_free();
      check("ready", 32'(bus_if.dispatch_ready_o), 32'(ff >= 0));
      if (ff >= 0) check("dispatch_id", 32'(bus_if.dispatch_id_o), 32'(ff));
      check("pending_wr", bus_if.pending_wr_o, m_pending());
      check("idle", 32'(bus_if.idle_o), 32'(m_idle()));
      check("err", 32'(bus_if.err_o), 32'(m_err));
      check("hazard", 32'(bus_if.hazard_o), 32'(|(bus_if.rd_mask_i & m_pending())));
    end
  end

  initial begin
    rst = 1'b1;
    set_idle();
    bus_if.rd_mask_i = '0;
    model_reset();

    // Reset state
    #12;
    check("rst_ready", 32'(bus_if.dispatch_ready_o), 32'h1);
    check("rst_id", 32'(bus_if.dispatch_id_o), 32'h0);
    check("rst_pending", bus_if.pending_wr_o, 32'h0);
    check("rst_hazard", 32'(bus_if.hazard_o), 32'h0);
    check("rst_idle", 32'(bus_if.idle_o), 32'h1);
    check("rst_err", 32'(bus_if.err_o), 32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;

    // 1: single dispatch then hazard lookup
    bus_if.dispatch_valid_i = 1'b1;
    bus_if.dispatch_pend_i  = 32'h0000_00F0;
    bus_if.rd_mask_i        = 32'h0000_00F0;
    @(negedge clk);
    check("t1_id", 32'(bus_if.dispatch_id_o), 32'h0);
    check("t1_no_bypass", 32'(bus_if.hazard_o), 32'h0);
    tick();
    set_idle();
    bus_if.rd_mask_i = 32'h10;
    @(negedge clk);
    check("t1_pending", bus_if.pending_wr_o, 32'h0000_00F0);
    check("t1_hazard_hit", 32'(bus_if.hazard_o), 32'h1);
    bus_if.rd_mask_i = 32'h1;
    #1;
    check("t1_hazard_miss", 32'(bus_if.hazard_o), 32'h0);
    bus_if.rd_mask_i       = '0;
    bus_if.retire_valid_i  = 1'b1;
    bus_if.retire_id_i     = 3'd0;
    tick();
    set_idle();

    // 2: fill all slots, retire+dispatch while full
    for (int i = 0; i < NS; i++) begin
      bus_if.dispatch_valid_i = 1'b1;
      bus_if.dispatch_pend_i  = 32'h1 << i;
      @(negedge clk);
      check("t2_fill_id", 32'(bus_if.dispatch_id_o), 32'(i));
      tick();
    end
    set_idle();
    @(negedge clk);
    check("t2_full_ready", 32'(bus_if.dispatch_ready_o), 32'h0);
    check("t2_full_pending", bus_if.pending_wr_o, 32'h0000_00FF);
    bus_if.retire_valid_i   = 1'b1;
    bus_if.retire_id_i      = 3'd3;
    bus_if.dispatch_valid_i = 1'b1;
    bus_if.dispatch_pend_i  = 32'h0000_1000;
    tick();
    set_idle();
    @(negedge clk);
    check("t2_ready_after_retire", 32'(bus_if.dispatch_ready_o), 32'h1);
    check("t2_id_after_retire", 32'(bus_if.dispatch_id_o), 32'h3);
    check("t2_pending_after_retire", bus_if.pending_wr_o, 32'h0000_00F7);
    bus_if.flush_i = 1'b1;
    tick();
    set_idle();

    // 3: partial clears keep the slot alive
    dispatch(32'h0000_0F00);
    bus_if.clear_valid_i = 1'b1;
    bus_if.clear_id_i    = 3'd0;
    bus_if.clear_mask_i  = 32'h0000_0300;
    tick();
    set_idle();
    @(negedge clk);
    check("t3_clear1", bus_if.pending_wr_o, 32'h0000_0C00);
    bus_if.clear_valid_i = 1'b1;
    bus_if.clear_id_i    = 3'd0;
    bus_if.clear_mask_i  = 32'h0000_0C00;
    tick();
    set_idle();
    @(negedge clk);
    check("t3_clear2", bus_if.pending_wr_o, 32'h0);
    check("t3_still_busy", 32'(bus_if.idle_o), 32'h0);
    bus_if.retire_valid_i = 1'b1;
    bus_if.retire_id_i    = 3'd0;
    tick();
    set_idle();
    @(negedge clk);
    check("t3_idle", 32'(bus_if.idle_o), 32'h1);

    // 4: same-slot clear+retire, then retire of a free slot
    dispatch(32'h0000_0010);
    dispatch(32'h0000_0003);
    bus_if.clear_valid_i  = 1'b1;
    bus_if.clear_id_i     = 3'd1;
    bus_if.clear_mask_i   = 32'h1;
    bus_if.retire_valid_i = 1'b1;
    bus_if.retire_id_i    = 3'd1;
    tick();
    set_idle();
    @(negedge clk);
    check("t4_pending", bus_if.pending_wr_o, 32'h0000_0010);
    check("t4_no_err", 32'(bus_if.err_o), 32'h0);
    check("t4_id_freed", 32'(bus_if.dispatch_id_o), 32'h1);
    bus_if.retire_valid_i = 1'b1;
    bus_if.retire_id_i    = 3'd1;
    tick();
    set_idle();
    @(negedge clk);
    check("t4_err_pulse", 32'(bus_if.err_o), 32'h1);
    check("t4_state_kept", bus_if.pending_wr_o, 32'h0000_0010);
    tick();
    @(negedge clk);
    check("t4_err_drop", 32'(bus_if.err_o), 32'h0);
    bus_if.flush_i = 1'b1;
    tick();
    set_idle();

    // 5: flush beats a concurrent dispatch
    dispatch(32'h0000_FF00);
    dispatch(32'hFF00_0000);
    bus_if.flush_i          = 1'b1;
    bus_if.dispatch_valid_i = 1'b1;
    bus_if.dispatch_pend_i  = 32'h0000_1234;
    tick();
    set_idle();
    @(negedge clk);
    check("t5_pending", bus_if.pending_wr_o, 32'h0);
    check("t5_idle", 32'(bus_if.idle_o), 32'h1);
    check("t5_id", 32'(bus_if.dispatch_id_o), 32'h0);

    // 6: asynchronous reset mid-cycle
    dispatch(32'h0000_000A);
    dispatch(32'h0000_0050);
    bus_if.rd_mask_i = 32'hFFFF_FFFF;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    $display("txn async reset");
    check("t6_pending", bus_if.pending_wr_o, 32'h0);
    check("t6_ready", 32'(bus_if.dispatch_ready_o), 32'h1);
    check("t6_idle", 32'(bus_if.idle_o), 32'h1);
    check("t6_hazard", 32'(bus_if.hazard_o), 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bus_if.flush_i          = ($urandom_range(0, 63) == 0);
      bus_if.dispatch_valid_i = ($urandom_range(0, 99) < 55);
      bus_if.dispatch_pend_i  = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & $urandom);
      bus_if.clear_valid_i    = ($urandom_range(0, 99) < 50);
      bus_if.clear_id_i       = 3'($urandom_range(0, 7));
      bus_if.clear_mask_i     = $urandom;
      bus_if.retire_valid_i   = ($urandom_range(0, 99) < 40);
      bus_if.retire_id_i      = 3'($urandom_range(0, 7));
      bus_if.rd_mask_i        = $urandom & $urandom & $urandom;
      tick();
    end
    set_idle();
    tick();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
